dif_twiddle_gen: RTL and testbench
==================================

# dif_twiddle_gen

- Twiddle-factor source for the DIF FFT butterfly datapath.
- Produces the complex coefficient W = br + i·bi that the complex multiplier consumes on its B operand, one coefficient per butterfly, for one FFT stage per run.
- Supports forward (W_N^e) and inverse (conjugate) transforms.
- Delivers coefficients over a valid/ready handshake so the butterfly control can stall it.

## Interface
- N_LOG2, 3: log2 of FFT size N. Legal range 3..12.
- TW_WIDTH, 16: signed coefficient width.
- clk  in  1  rising-edge clock.
- reset_n  in  1  reset, synchronous and active-low.
- start  in  1  single-cycle run request; honoured only in IDLE.
- stage  in  4  FFT stage s for this run, sampled with start.
- inv  in  1  1 = inverse transform (conjugate coefficients), sampled with start.
- tw_valid  out  1  br/bi/tw_idx/tw_last hold a valid beat.
- tw_ready  in  1  consumer accepts the beat when tw_valid && tw_ready.
- br  out  TW_WIDTH  signed real part.
- bi  out  TW_WIDTH  signed imaginary part.
- tw_idx  out  N_LOG2-1  exponent e of the current beat.
- tw_last  out  1  marks the final beat (j = N/2-1) of the run.
- busy  out  1  high from start acceptance until the last beat is transferred.
- err  out  1  one-cycle pulse when start arrives in IDLE with stage ≥ N_LOG2.

## Operation
- States: IDLE, LOAD, RUN.
- IDLE, start=1, stage<N_LOG2: latch stage and inv, clear beat counter j, go to LOAD.
- IDLE, start=1, stage≥N_LOG2: pulse err, stay in IDLE.
- LOAD: register beat j=0 onto the outputs, set tw_valid=1, go to RUN.
- RUN, transfer with j<N/2-1: increment j and register the next beat in the same edge. Sustains one beat per cycle.
- RUN, transfer with j=N/2-1 (tw_last=1): go to IDLE. tw_valid, tw_last and busy drop on that edge.
- RUN, no transfer: every output holds stable.
- start outside IDLE: ignored, no err.
- Beat j exponent: e = (j mod (N>>(s+1))) << s, so 0 ≤ e < N/2.
  - s=0 gives e=j.
  - Last stage gives e=0 on every beat.
- Amplitude: A = 2^(TW_WIDTH-1)-1.
- Forward coefficients:
  - br = round(A·cos(2πe/N))
  - bi = −round(A·sin(2πe/N))
- Rounding is half away from zero.
- inv=1: bi is negated. br is unchanged.
- Table: quarter-wave constant table Q[m] = round(A·sin(2πm/N)), m = 0..N/4, built at elaboration with no runtime arithmetic beyond negation.
  - e ≤ N/4: cos = Q[N/4−e], sin = Q[e].
  - e > N/4: cos = −Q[e−N/4], sin = Q[N/2−e].
- Negated values never overflow because |Q| ≤ A.
- reset_n=0 at any clock edge, including mid-run: next state IDLE, j=0.
  - Every output goes to 0 on that edge: tw_valid, br, bi, tw_idx, tw_last, busy, err.
  - A run in progress is abandoned with no further beats.

## Timing
- All outputs are registered. Reset value of every output is 0.
- start sampled at edge k:
  - busy=1 after edge k.
  - tw_valid=1 with beat 0 after edge k+1. Latency is 2 edges.
- With tw_ready held high, a run is N/2 consecutive beats.
  - tw_last rises after edge k+N/2.
  - busy and tw_valid fall after edge k+N/2+1.
  - A new start is accepted at edge k+N/2+2 at the earliest.
- tw_ready low has no effect outside RUN.
- tw_valid never drops without a transfer except on reset.
- err asserts after the sampling edge and clears one edge later.

## Test plan
Settings: N_LOG2=3 (N=8), TW_WIDTH=16, A=32767.
- **Stage 0, forward, tw_ready=1:** start, stage=0, inv=0 → 4 beats on consecutive cycles:
  - e = 0, 1, 2, 3.
  - (br, bi) = (32767, 0), (23170, −23170), (0, −32767), (−23170, −23170).
  - tw_last on beat 3. busy covers 5 cycles.
- **Stages 1 and 2:** stage=1 → e = 0, 2, 0, 2. stage=2 → e = 0, 0, 0, 0 with (32767, 0) on every beat.
- **Inverse with backpressure:** start, stage=0, inv=1, tw_ready low 3 cycles on beat 1 →
  - Beat 1 is held stable at (23170, +23170) for all stalled cycles.
  - Beats are neither skipped nor repeated.
- **Illegal and busy starts:** start with stage=3 → err pulse for one cycle, busy stays 0. Then start during RUN → ignored, run completes unchanged.
- **Reset mid-run:** reset_n=0 for one edge during beat 2 → all outputs 0 on the next edge. A new start afterward runs cleanly from e=0.
- **Back-to-back runs:** start at the earliest legal edge after a run → latency is again 2 edges, with no residual tw_last or err.

Source files
------------

// File: rtl/dif_twiddle_gen_if.sv
// Coefficient beat channel between the twiddle generator and the butterfly multiplier.
// The generator drives the beat fields; the consumer drives tw_ready to stall it.
interface dif_twiddle_gen_if #(
    parameter int N_LOG2   = 3,
    parameter int TW_WIDTH = 16
);
    logic                       tw_valid;
    logic                       tw_ready;
    logic signed [TW_WIDTH-1:0] br;
    logic signed [TW_WIDTH-1:0] bi;
    logic [N_LOG2-2:0]          tw_idx;
    logic                       tw_last;

    modport master (
        output tw_valid,
        output br,
        output bi,
        output tw_idx,
        output tw_last,
        input  tw_ready
    );

    modport slave (
        input  tw_valid,
        input  br,
        input  bi,
        input  tw_idx,
        input  tw_last,
        output tw_ready
    );
endinterface

// File: rtl/dif_twiddle_gen.sv
// Twiddle-factor source for one DIF FFT stage: streams N/2 coefficients W_N^e
// (or their conjugates) from a quarter-wave sine table over a valid/ready channel.
module dif_twiddle_gen #(
    parameter int N_LOG2   = 3,
    parameter int TW_WIDTH = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [3:0]          stage,
    input  logic                inv,
    dif_twiddle_gen_if.master   tw,
    output logic                busy,
    output logic                err
);
    localparam int  N   = 1 << N_LOG2;
    localparam int  QN  = N / 4;
    localparam int  EW  = N_LOG2 - 1;
    localparam real PI  = 3.14159265358979323846;
    localparam real AMP = real'((64'd1 << (TW_WIDTH - 1)) - 64'd1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam logic [EW-1:0] QN_E   = EW'(QN);
    localparam logic [EW-1:0] J_MASK = '1;

    // Quarter-wave table Q[m] = round(A*sin(2*pi*m/N)); every entry is non-negative,
    // so adding one half and truncating rounds half away from zero.
    function automatic logic [(QN+1)*TW_WIDTH-1:0] build_quarter_table();
        logic [(QN+1)*TW_WIDTH-1:0] t;
        logic [31:0]                r;
        real                        v;
        t = '0;
        for (int m = 0; m <= QN; m++) begin
            v = AMP * $sin(2.0 * PI * real'(m) / real'(N));
            r = $rtoi(v + 0.5);
            t[m*TW_WIDTH +: TW_WIDTH] = r[TW_WIDTH-1:0];
        end
        return t;
    endfunction

    localparam logic [(QN+1)*TW_WIDTH-1:0] Q_FLAT = build_quarter_table();

    logic signed [TW_WIDTH-1:0] q_rom [QN+1];

    for (genvar g = 0; g <= QN; g++) begin : g_rom
        assign q_rom[g] = Q_FLAT[g*TW_WIDTH +: TW_WIDTH];
    end

    logic [1:0]                 state_q, state_d;
    logic [3:0]                 stage_q, stage_d;
    logic                       inv_q, inv_d;
    logic [EW-1:0]              j_q, j_d;
    logic                       tw_valid_q, tw_valid_d;
    logic signed [TW_WIDTH-1:0] br_q, br_d;
    logic signed [TW_WIDTH-1:0] bi_q, bi_d;
    logic [EW-1:0]              tw_idx_q, tw_idx_d;
    logic                       tw_last_q, tw_last_d;
    logic                       busy_q, busy_d;
    logic                       err_q, err_d;

    logic [EW-1:0]              beat_j;
    logic [EW-1:0]              beat_e;
    logic [EW-1:0]              cos_idx;
    logic [EW-1:0]              sin_idx;
    logic                       cos_neg;
    logic signed [TW_WIDTH-1:0] cos_v;
    logic signed [TW_WIDTH-1:0] sin_v;
    logic signed [TW_WIDTH-1:0] beat_br;
    logic signed [TW_WIDTH-1:0] beat_bi;

    // Coefficient for the beat about to be registered: beat 0 in LOAD, j+1 in RUN.
    // Masking j by (N/2-1)>>s is the mod-(N>>(s+1)) step, since N is a power of two.
    always_comb begin
        beat_j  = (state_q == ST_RUN) ? j_q + EW'(1) : j_q;
        beat_e  = (beat_j & (J_MASK >> stage_q)) << stage_q;
        cos_idx = QN_E - beat_e;
        sin_idx = beat_e;
        cos_neg = 1'b0;
        if (beat_e > QN_E) begin
            cos_idx = beat_e - QN_E;
            sin_idx = -beat_e;
            cos_neg = 1'b1;
        end
        cos_v   = cos_neg ? -q_rom[cos_idx] : q_rom[cos_idx];
        sin_v   = q_rom[sin_idx];
        beat_br = cos_v;
        beat_bi = inv_q ? sin_v : -sin_v;
    end

    always_comb begin
        state_d    = state_q;
        stage_d    = stage_q;
        inv_d      = inv_q;
        j_d        = j_q;
        tw_valid_d = tw_valid_q;
        br_d       = br_q;
        bi_d       = bi_q;
        tw_idx_d   = tw_idx_q;
        tw_last_d  = tw_last_q;
        busy_d     = busy_q;
        err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (stage < 4'(N_LOG2)) begin
                        state_d = ST_LOAD;
                        stage_d = stage;
                        inv_d   = inv;
                        j_d     = '0;
                        busy_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                state_d    = ST_RUN;
                tw_valid_d = 1'b1;
                tw_idx_d   = beat_e;
                br_d       = beat_br;
                bi_d       = beat_bi;
                tw_last_d  = &beat_j;
            end
            ST_RUN: begin
                if (tw_valid_q && tw.tw_ready) begin
                    if (tw_last_q) begin
                        state_d    = ST_IDLE;
                        tw_valid_d = 1'b0;
                        tw_last_d  = 1'b0;
                        busy_d     = 1'b0;
                        j_d        = '0;
                    end else begin
                        j_d       = beat_j;
                        tw_idx_d  = beat_e;
                        br_d      = beat_br;
                        bi_d      = beat_bi;
                        tw_last_d = &beat_j;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            stage_q    <= '0;
            inv_q      <= 1'b0;
            j_q        <= '0;
            tw_valid_q <= 1'b0;
            br_q       <= '0;
            bi_q       <= '0;
            tw_idx_q   <= '0;
            tw_last_q  <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            inv_q      <= inv_d;
            j_q        <= j_d;
            tw_valid_q <= tw_valid_d;
            br_q       <= br_d;
            bi_q       <= bi_d;
            tw_idx_q   <= tw_idx_d;
            tw_last_q  <= tw_last_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign tw.tw_valid = tw_valid_q;
    assign tw.br       = br_q;
    assign tw.bi       = bi_q;
    assign tw.tw_idx   = tw_idx_q;
    assign tw.tw_last  = tw_last_q;
    assign busy        = busy_q;
    assign err         = err_q;
endmodule

// File: tb/tb_dif_twiddle_gen.sv
// Scoreboard bench for dif_twiddle_gen: expected beats come from a trigonometric
// reference model and are matched in order against every transferred beat.
module tb_dif_twiddle_gen;
    localparam int  N_LOG2   = 3;
    localparam int  TW_WIDTH = 16;
    localparam int  N        = 1 << N_LOG2;
    localparam int  HALF     = N / 2;
    localparam real PI       = 3.14159265358979323846;

    typedef struct {
        int e;
        int br;
        int bi;
        bit last;
    } beat_t;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       start   = 1'b0;
    logic [3:0] stage   = 4'd0;
    logic       inv     = 1'b0;
    logic       busy;
    logic       err;

    dif_twiddle_gen_if #(.N_LOG2(N_LOG2), .TW_WIDTH(TW_WIDTH)) twif ();

    dif_twiddle_gen #(.N_LOG2(N_LOG2), .TW_WIDTH(TW_WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .stage   (stage),
        .inv     (inv),
        .tw      (twif),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    beat_t exp_q[$];
    int    errors     = 0;
    int    checks     = 0;
    int    ready_mode = 0;
    int    cyc        = 0;
    int    stall_end  = -1;

    int plan_br [4] = '{32767, 23170, 0, -23170};
    int plan_bi [4] = '{0, -23170, -32767, -23170};

    task automatic checkOutput(input string name, input longint actual, input longint required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, required %0d (t=%0t)", name, actual, required, $time);
        end
    endtask

    function automatic int round_haz(input real x);
        if (x >= 0.0) return int'($floor(x + 0.5));
        return -int'($floor(-x + 0.5));
    endfunction

    // Reference: exponent from the stage rule, coefficient straight from cos/sin.
    function automatic beat_t model_beat(input int j, input int s, input bit iv);
        beat_t b;
        real   amp;
        real   ang;
        int    period;
        period = N >> (s + 1);
        b.e    = (j % period) << s;
        amp    = real'((64'd1 << (TW_WIDTH - 1)) - 64'd1);
        ang    = 2.0 * PI * real'(b.e) / real'(N);
        b.br   = round_haz(amp * $cos(ang));
        b.bi   = -round_haz(amp * $sin(ang));
        if (iv) b.bi = -b.bi;
        b.last = (j == HALF - 1);
        return b;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Caller sits just after a rising edge; start is sampled on the next edge.
    task automatic applyStimulus(input logic [3:0] s, input logic iv, input bit push,
                                 input bit exp_busy, input bit exp_err);
        start = 1'b1;
        stage = s;
        inv   = iv;
        if (push) begin
            for (int j = 0; j < HALF; j++) exp_q.push_back(model_beat(j, int'(s), iv));
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("busy_after_start", busy, exp_busy);
        checkOutput("err_after_start", err, exp_err);
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            step(1);
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d beats pending, required 0", exp_q.size());
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_tw_valid"}, twif.tw_valid, 0);
        checkOutput({tag, "_br"}, twif.br, 0);
        checkOutput({tag, "_bi"}, twif.bi, 0);
        checkOutput({tag, "_tw_idx"}, twif.tw_idx, 0);
        checkOutput({tag, "_tw_last"}, twif.tw_last, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_err"}, err, 0);
    endtask

    // Consumer ready: held high, randomised, or forced low through a stall window.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (cyc <= stall_end) twif.tw_ready = 1'b0;
            else if (ready_mode != 0) twif.tw_ready = 1'($urandom_range(0, 1));
            else twif.tw_ready = 1'b1;
        end
    end

    // Monitor: pops the scoreboard on each transfer and checks stalled beats hold still.
    initial begin
        bit                         held;
        logic signed [TW_WIDTH-1:0] held_br;
        logic signed [TW_WIDTH-1:0] held_bi;
        logic [N_LOG2-2:0]          held_idx;
        logic                       held_last;
        beat_t                      b;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    checkOutput("stall_valid", twif.tw_valid, 1);
                    checkOutput("stall_br", twif.br, held_br);
                    checkOutput("stall_bi", twif.bi, held_bi);
                    checkOutput("stall_idx", twif.tw_idx, held_idx);
                    checkOutput("stall_last", twif.tw_last, held_last);
                end
                if (twif.tw_valid && twif.tw_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_beat: got idx %0d, required no beat", twif.tw_idx);
                    end else begin
                        b = exp_q.pop_front();
                        checkOutput("beat_idx", twif.tw_idx, b.e);
                        checkOutput("beat_br", twif.br, b.br);
                        checkOutput("beat_bi", twif.bi, b.bi);
                        checkOutput("beat_last", twif.tw_last, b.last);
                    end
                end
                held      = twif.tw_valid && !twif.tw_ready;
                held_br   = twif.br;
                held_bi   = twif.bi;
                held_idx  = twif.tw_idx;
                held_last = twif.tw_last;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got no finish, required finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        $display("[TB] dif_twiddle_gen bench, N=%0d", N);

        step(2);
        checkAllZero("reset");
        reset_n = 1'b1;
        step(1);

        // Stage 0 forward with ready high: latency, literal coefficients, busy window.
        applyStimulus(4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("load_valid_low", twif.tw_valid, 0);
        for (int b = 0; b < HALF; b++) begin
            step(1);
            checkOutput("s0_valid", twif.tw_valid, 1);
            checkOutput("s0_br", twif.br, plan_br[b]);
            checkOutput("s0_bi", twif.bi, plan_bi[b]);
            checkOutput("s0_last", twif.tw_last, (b == HALF - 1) ? 1 : 0);
        end
        step(1);
        checkOutput("s0_busy_end", busy, 0);
        checkOutput("s0_valid_end", twif.tw_valid, 0);
        waitDrain();

        applyStimulus(4'd1, 1'b0, 1'b1, 1'b1, 1'b0);
        waitDrain();
        applyStimulus(4'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        waitDrain();

        // Inverse run with beat 1 stalled for three cycles.
        applyStimulus(4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(2);
        stall_end = cyc + 3;
        for (int t = 0; t < 4; t++) begin
            if (t > 0) step(1);
            checkOutput("inv_stall_valid", twif.tw_valid, 1);
            checkOutput("inv_stall_idx", twif.tw_idx, 1);
            checkOutput("inv_stall_br", twif.br, 23170);
            checkOutput("inv_stall_bi", twif.bi, 23170);
        end
        waitDrain();

        // Illegal stages pulse err for one cycle only.
        applyStimulus(4'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1);
        checkOutput("err_clears", err, 0);
        checkOutput("illegal_busy_low", busy, 0);
        applyStimulus(4'd15, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1);
        checkOutput("err_clears_15", err, 0);

        // Start during RUN is ignored; scoreboard confirms the original run.
        applyStimulus(4'd1, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1);
        applyStimulus(4'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        waitDrain();

        // Reset while beat 2 is presented, then a clean run.
        applyStimulus(4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(3);
        checkOutput("pre_reset_idx", twif.tw_idx, 2);
        reset_n = 1'b0;
        step(1);
        checkAllZero("midrun_reset");
        exp_q.delete();
        reset_n = 1'b1;
        applyStimulus(4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        waitDrain();

        // Back-to-back: second start at the earliest legal edge.
        applyStimulus(4'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(HALF + 1);
        applyStimulus(4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("b2b_valid_low", twif.tw_valid, 0);
        step(1);
        checkOutput("b2b_valid", twif.tw_valid, 1);
        checkOutput("b2b_idx", twif.tw_idx, 0);
        checkOutput("b2b_last", twif.tw_last, 0);
        checkOutput("b2b_err", err, 0);
        waitDrain();

        // Randomised stage/direction with random backpressure.
        ready_mode = 1;
        repeat (8) begin
            applyStimulus(4'($urandom_range(0, N_LOG2 - 1)), 1'($urandom_range(0, 1)),
                          1'b1, 1'b1, 1'b0);
            waitDrain();
        end
        ready_mode = 0;
        step(2);

        checkOutput("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
